fwd_clk_rx: RTL and testbench

Receive side of the forwarded-clock link. A remote board drives a source clock, frame and serial data; this block oversamples all three with the system clock and deserializes them into WIDTH-bit words. It presents each word through a one-entry holding register with a valid/acknowledge handshake. It sits behind the I/O pins, feeding the console/bus interface logic.

---
 rtl/fwd_clk_rx_pkg.sv | 13 +
 rtl/fwd_clk_rx_if.sv | 27 ++
 rtl/fwd_clk_rx_sync_bit.sv | 24 ++
 rtl/fwd_clk_rx.sv | 124 ++++++++++++
 tb/tb_fwd_clk_rx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_clk_rx_pkg.sv
// Shared definitions for the forwarded-clock receiver: FSM encoding and
// default word/synchronizer sizing.
package fwd_clk_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 36;
    localparam int DEF_SYNC  = 2;

endpackage

// File: rtl/fwd_clk_rx_if.sv
// Pin-side and consumer-side signals of the forwarded-clock receiver.
// The master is the receiver; the slave is the remote pins plus consumer.
interface fwd_clk_rx_if
    import fwd_clk_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             rx_clk;
    logic             rx_frm;
    logic             rx_dat;
    logic             ack;
    logic             clr;
    logic [WIDTH-1:0] data;
    logic             vld;
    logic             ovr;
    logic             ferr;

    modport master (
        input  rx_clk, rx_frm, rx_dat, ack, clr,
        output data, vld, ovr, ferr
    );

    modport slave (
        output rx_clk, rx_frm, rx_dat, ack, clr,
        input  data, vld, ovr, ferr
    );
endinterface

// File: rtl/fwd_clk_rx_sync_bit.sv
// Multi-flop synchronizer for one asynchronous pin; the output is the last
// flop of the chain and every flop clears to 0 on reset.
module sync_bit
    import fwd_clk_rx_pkg::*;
#(
    parameter int SYNC = DEF_SYNC
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC-1:0] chain_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC-2:0], d};
        end
    end

    assign q = chain_reg[SYNC-1];
endmodule

// File: rtl/fwd_clk_rx.sv
// Forwarded-clock receiver: oversamples rx_clk/rx_frm/rx_dat, deserializes
// MSB-first words on rx_clk rising edges and holds them for a valid/ack consumer.
module fwd_clk_rx
    import fwd_clk_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SYNC  = DEF_SYNC
) (
    input  logic          clk,
    input  logic          rst,
    fwd_clk_rx_if.master  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2:0]       pin_vec;
    logic [2:0]       sync_vec;
    logic             clk_s, frm_s, dat_s;
    logic             clk_d_reg;
    logic             bit_edge;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] word_full;
    logic             word_done;
    logic             ferr_reg, ferr_next;
    logic [WIDTH-1:0] data_reg;
    logic             vld_reg;
    logic             ovr_reg;

    // Identical chains keep the three pins aligned to each other after sync.
    assign pin_vec = {bus.rx_clk, bus.rx_frm, bus.rx_dat};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_bit #(.SYNC(SYNC)) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (pin_vec[gi]),
                .q   (sync_vec[gi])
            );
        end
    endgenerate

    assign clk_s    = sync_vec[2];
    assign frm_s    = sync_vec[1];
    assign dat_s    = sync_vec[0];
    assign bit_edge = clk_s & ~clk_d_reg;
    assign word_full = {shift_reg[WIDTH-2:0], dat_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_d_reg <= 1'b0;
            state_reg <= ST_IDLE;
            count_reg <= '0;
            shift_reg <= '0;
            ferr_reg  <= 1'b0;
        end else begin
            clk_d_reg <= clk_s;
            state_reg <= state_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        ferr_next  = 1'b0;
        word_done  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                if (frm_s) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!frm_s) begin
                    // Frame dropped; only a partially received word is an error.
                    state_next = ST_IDLE;
                    count_next = '0;
                    ferr_next  = (count_reg != '0);
                end else if (bit_edge) begin
                    shift_next = word_full;
                    if (count_reg == LAST) begin
                        word_done  = 1'b1;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Holding register: a new word always wins; ovr only when it displaces an unacked one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            if (word_done) begin
                data_reg <= word_full;
                vld_reg  <= 1'b1;
            end else if (bus.ack) begin
                vld_reg  <= 1'b0;
            end
            if (word_done && vld_reg && !bus.ack) begin
                ovr_reg <= 1'b1;
            end else if (bus.clr) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign bus.data = data_reg;
    assign bus.vld  = vld_reg;
    assign bus.ovr  = ovr_reg;
    assign bus.ferr = ferr_reg;
endmodule

// File: tb/tb_fwd_clk_rx.sv
// Self-checking bench for fwd_clk_rx: drives the forwarded link at 1/8 clk rate
// and compares outputs to a word-level model of the holding register.
module tb_fwd_clk_rx;
    import fwd_clk_rx_pkg::*;

    localparam int W    = 36;
    localparam int SYNC = 2;
    localparam int H    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    fwd_clk_rx_if #(.WIDTH(W)) bus ();

    fwd_clk_rx #(.WIDTH(W), .SYNC(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: what the consumer should see, word by word.
    logic [W-1:0] exp_data;
    logic         exp_vld;
    logic         exp_ovr;
    int           exp_ferr;
    logic [W-1:0] exp_q[$];

    // Observations gathered from the DUT.
    logic [W-1:0] got_q[$];
    int           ferr_seen = 0;
    int           rise_cyc = 0;
    int           vld_rise_cyc = 0;
    logic         vld_q = 1'b0;

    always @(negedge clk) begin
        if (bus.vld && bus.ack) got_q.push_back(bus.data);
        if (bus.ferr) ferr_seen++;
        if (bus.vld && !vld_q) vld_rise_cyc = cyc;
        vld_q = bus.vld;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"}, 64'(bus.data), 64'(exp_data));
        chk({tag, "_vld"},  64'(bus.vld),  64'(exp_vld));
        chk({tag, "_ovr"},  64'(bus.ovr),  64'(exp_ovr));
        chk({tag, "_ferr_count"}, 64'(ferr_seen), 64'(exp_ferr));
    endtask

    task automatic check_acked(input string tag);
        chk({tag, "_acked_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_acked_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // mode 0: no ack; 1: ack in the completion cycle; 2: ack the cycle after vld
    function automatic void model_word(input logic [W-1:0] w, input int mode);
        if (mode == 1) begin
            if (exp_vld) exp_q.push_back(exp_data);
        end else if (exp_vld) begin
            exp_ovr = 1'b1;
        end
        exp_data = w;
        exp_vld  = 1'b1;
        if (mode == 2) begin
            exp_q.push_back(w);
            exp_vld = 1'b0;
        end
    endfunction

    task automatic send_bit(input logic b, input int mode);
        bus.rx_dat = b;
        bus.rx_clk = 1'b0;
        tick(H);
        bus.rx_clk = 1'b1;
        rise_cyc = cyc;
        if (mode == 1) begin
            tick(SYNC);
            bus.ack = 1'b1;
            tick(1);
            bus.ack = 1'b0;
            tick(H - SYNC - 1);
        end else if (mode == 2) begin
            tick(SYNC + 1);
            bus.ack = 1'b1;
            tick(1);
            bus.ack = 1'b0;
            tick(H - SYNC - 2);
        end else begin
            tick(H);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int mode);
        for (int i = 0; i < n; i++)
            send_bit(w[W-1-i], (i == n - 1) ? mode : 0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int mode);
        $display("word %o mode %0d at cycle %0d", w, mode, cyc);
        send_bits(w, W, mode);
        model_word(w, mode);
    endtask

    task automatic begin_frame();
        bus.rx_frm = 1'b1;
        tick(H);
    endtask

    task automatic end_frame();
        bus.rx_clk = 1'b0;
        tick(H);
        bus.rx_frm = 1'b0;
        tick(SYNC + 4);
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        if (exp_vld) exp_q.push_back(exp_data);
        exp_vld = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        int lat, k, nw, md;

        bus.rx_clk = 1'b0;
        bus.rx_frm = 1'b0;
        bus.rx_dat = 1'b0;
        bus.ack    = 1'b0;
        bus.clr    = 1'b0;
        exp_data = '0;
        exp_vld  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 0;

        tick(3);
        check_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Single word, latency and content
        begin_frame();
        send_word(36'o123456701234, 0);
        lat = vld_rise_cyc - rise_cyc;
        chk("vld_latency_in_window", 64'(lat >= SYNC + 1 && lat <= SYNC + 2), 64'd1);
        end_frame();
        check_outputs("single");
        pulse_ack();
        check_acked("single");

        // Back-to-back words, each acked after vld
        begin_frame();
        send_word(36'o1, 2);
        send_word(36'o777777777777, 2);
        end_frame();
        check_outputs("b2b_ack");
        check_acked("b2b_ack");

        // Two words without ack -> overrun, then clear
        begin_frame();
        send_word(36'o1, 0);
        send_word(36'o777777777777, 0);
        end_frame();
        check_outputs("overrun");
        pulse_clr();
        check_outputs("overrun_clr");
        pulse_ack();
        check_acked("overrun");

        // Frame abort after 17 bits, then a clean word
        begin_frame();
        send_bits(36'o525252525252, 17, 0);
        end_frame();
        exp_ferr++;
        check_outputs("abort");
        begin_frame();
        send_word(36'o525252525252, 0);
        end_frame();
        check_outputs("after_abort");

        // Ack coincident with completion of the second word
        pulse_ack();
        begin_frame();
        send_word(36'o1234, 0);
        send_word(36'o765432107654, 1);
        end_frame();
        check_outputs("ack_same_cycle");
        check_acked("ack_same_cycle");

        // Reset in the middle of a word
        begin_frame();
        send_bits(36'o777000777000, 10, 0);
        rst = 1'b1;
        #1;
        chk("midrst_data", 64'(bus.data), 64'd0);
        chk("midrst_vld",  64'(bus.vld),  64'd0);
        chk("midrst_ovr",  64'(bus.ovr),  64'd0);
        chk("midrst_ferr", 64'(bus.ferr), 64'd0);
        exp_data = '0;
        exp_vld  = 1'b0;
        exp_ovr  = 1'b0;
        bus.rx_clk = 1'b0;
        bus.rx_frm = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        begin_frame();
        send_word(36'o4, 0);
        end_frame();
        check_outputs("after_rst");
        pulse_ack();
        check_acked("after_rst");

        // Randomized frames against the model
        for (int it = 0; it < 10; it++) begin
            nw = $urandom_range(1, 3);
            begin_frame();
            for (int j = 0; j < nw; j++) begin
                w  = W'({$urandom, $urandom});
                md = $urandom_range(0, 2);
                send_word(w, md);
            end
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, W - 1);
                w = W'({$urandom, $urandom});
                $display("abort after %0d bits at cycle %0d", k, cyc);
                send_bits(w, k, 0);
                exp_ferr++;
            end
            end_frame();
            check_outputs("rand");
            if ($urandom_range(0, 1) == 1) pulse_clr();
            if ($urandom_range(0, 1) == 1) pulse_ack();
            check_outputs("rand_post");
            check_acked("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
